// File: rtl/seq_multiplier_4x4.sv
// Sequential 4x4 unsigned shift-add multiplier, one partial product per cycle.
// Ports: clk, rst_n (async, active-low), start, A[3:0], B[3:0] in;
//        busy, done (1-cycle pulse), Product[7:0] (registered A*B) out.

module ripple_carry_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_carry
);
    logic w_c1, w_c2, w_c3;

    assign o_sum[0] = i_a[0] ^ i_b[0] ^ i_cin;
    assign w_c1     = (i_a[0] & i_b[0]) | (i_cin & (i_a[0] ^ i_b[0]));
    assign o_sum[1] = i_a[1] ^ i_b[1] ^ w_c1;
    assign w_c2     = (i_a[1] & i_b[1]) | (w_c1 & (i_a[1] ^ i_b[1]));
    assign o_sum[2] = i_a[2] ^ i_b[2] ^ w_c2;
    assign w_c3     = (i_a[2] & i_b[2]) | (w_c2 & (i_a[2] ^ i_b[2]));
    assign o_sum[3] = i_a[3] ^ i_b[3] ^ w_c3;
    assign o_carry  = (i_a[3] & i_b[3]) | (w_c3 & (i_a[3] ^ i_b[3]));
endmodule

module seq_multiplier_4x4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       busy,
    output logic       done,
    output logic [7:0] Product
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_m, r_q, r_acc;
    logic       r_c;
    logic [1:0] r_cnt;
    logic [7:0] r_product;

    logic [3:0] w_m_nxt, w_q_nxt, w_acc_nxt;
    logic       w_c_nxt;
    logic [1:0] w_cnt_nxt;
    logic [7:0] w_product_nxt;

    logic [3:0] w_sum;
    logic       w_carry;
    logic       w_c_pre;
    logic [3:0] w_acc_pre;
    logic [8:0] w_shift;

    ripple_carry_adder u_adder (
        .i_a     (r_acc),
        .i_b     (r_m),
        .i_cin   (1'b0),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // FSM next state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (r_cnt == 2'd3) w_state_nxt = DONE;
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: conditional add then right shift of {C,ACC,Q}, same edge
    always_comb begin
        w_m_nxt       = r_m;
        w_q_nxt       = r_q;
        w_acc_nxt     = r_acc;
        w_c_nxt       = r_c;
        w_cnt_nxt     = r_cnt;
        w_product_nxt = r_product;
        w_c_pre       = r_q[0] ? w_carry : 1'b0;
        w_acc_pre     = r_q[0] ? w_sum : r_acc;
        w_shift       = {w_c_pre, w_acc_pre, r_q} >> 1;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_m_nxt   = A;
                    w_q_nxt   = B;
                    w_acc_nxt = 4'd0;
                    w_c_nxt   = 1'b0;
                    w_cnt_nxt = 2'd0;
                end
            end
            CALC: begin
                {w_c_nxt, w_acc_nxt, w_q_nxt} = w_shift;
                w_cnt_nxt = r_cnt + 2'd1;
                // Only the final iteration publishes, so no partial product leaks
                if (r_cnt == 2'd3) w_product_nxt = w_shift[7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_m       <= 4'd0;
            r_q       <= 4'd0;
            r_acc     <= 4'd0;
            r_c       <= 1'b0;
            r_cnt     <= 2'd0;
            r_product <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_m       <= w_m_nxt;
            r_q       <= w_q_nxt;
            r_acc     <= w_acc_nxt;
            r_c       <= w_c_nxt;
            r_cnt     <= w_cnt_nxt;
            r_product <= w_product_nxt;
        end
    end

    assign Product = r_product;
endmodule

// File: tb/tb_seq_multiplier_4x4.sv
// Bench for seq_multiplier_4x4: vector table, corner sequences, full sweep.
// Expected products are queued at stimulus time and popped on each done.

module tb_seq_multiplier_4x4;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] A, B;
    logic       busy, done;
    logic [7:0] Product;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    logic [7:0] sb[$];
    bit         sweep_mode = 1'b0;
    bit         sweep_first = 1'b1;
    time        last_done = 0;

    seq_multiplier_4x4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Product (Product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Output monitor: every done pops one expected product
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else chk("product", {24'd0, Product}, {24'd0, sb.pop_front()});
            if (sweep_mode) begin
                if (!sweep_first) chk("done_spacing", 32'($time - last_done), 60);
                sweep_first = 1'b0;
            end
            last_done = $time;
        end
    end

    task automatic wait_done(output int at);
        at = 0;
        for (int i = 1; i <= 20 && at == 0; i++) begin
            @(negedge clk);
            if (done === 1'b1) at = i;
        end
        if (at == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp);
        int at;
        A = a;
        B = b;
        start = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        A = 4'($urandom);
        B = 4'($urandom);
        wait_done(at);
        chk("latency", at, 4);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("product_held", {24'd0, Product}, {24'd0, exp});
    endtask

    initial begin
        vec_t vt[10];
        int   bcnt, dat, dpl, d0;

        vt[0] = '{4'd13, 4'd11, 8'd143};
        vt[1] = '{4'd15, 4'd15, 8'd225};
        vt[2] = '{4'd0,  4'd9,  8'd0};
        vt[3] = '{4'd9,  4'd0,  8'd0};
        vt[4] = '{4'd1,  4'd1,  8'd1};
        vt[5] = '{4'd8,  4'd8,  8'd64};
        vt[6] = '{4'd7,  4'd6,  8'd42};
        vt[7] = '{4'd15, 4'd1,  8'd15};
        vt[8] = '{4'd1,  4'd15, 8'd15};
        vt[9] = '{4'd10, 4'd5,  8'd50};

        rst_n = 1'b0;
        start = 1'b0;
        A = 4'd0;
        B = 4'd0;
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_product", {24'd0, Product}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 13*11: busy width and done position
        A = 4'd13;
        B = 4'd11;
        start = 1'b1;
        sb.push_back(8'h8F);
        @(negedge clk);
        start = 1'b0;
        bcnt = 0;
        dat = 0;
        dpl = 0;
        for (int k = 1; k <= 10; k++) begin
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                if (dat == 0) dat = k;
                dpl++;
            end
            @(negedge clk);
        end
        chk("busy_cycles", bcnt, 5);
        chk("done_at", dat, 5);
        chk("done_pulses", dpl, 1);

        for (int i = 0; i < 10; i++) run_op(vt[i].a, vt[i].b, vt[i].exp);

        // start during CALC is ignored
        A = 4'd3;
        B = 4'd5;
        start = 1'b1;
        sb.push_back(8'h0F);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        A = 4'd7;
        B = 4'd7;
        @(negedge clk);
        start = 1'b0;
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        chk("ignored_start_dones", done_cnt - d0, 1);
        chk("ignored_start_busy", {31'd0, busy}, 0);
        chk("ignored_start_product", {24'd0, Product}, 32'h0F);

        // reset mid-operation aborts asynchronously
        A = 4'd12;
        B = 4'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_product", {24'd0, Product}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_product", {24'd0, Product}, 0);
        run_op(4'd2, 4'd3, 8'h06);

        // all 256 pairs with start held high
        sweep_mode = 1'b1;
        sweep_first = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 256; i++) begin
            A = 4'(i >> 4);
            B = 4'(i & 15);
            start = 1'b1;
            sb.push_back(8'((i >> 4) * (i & 15)));
            repeat (6) @(negedge clk);
        end
        start = 1'b0;
        sweep_mode = 1'b0;
        chk("sweep_dones", done_cnt - d0, 256);
        repeat (4) @(negedge clk);
        chk("queue_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_multiplier_4x4.md
SEQ_MULTIPLIER_4X4 -- requirements
Module: seq_multiplier_4x4

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits, product width at 8 bits.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin one multiplication; sampled only in IDLE.
REQ-005 A  input  4  unsigned multiplicand; captured on the accepting edge.
REQ-006 B  input  4  unsigned multiplier; captured on the accepting edge.
REQ-007 busy  output  1  high while an operation is in progress (CALC or DONE).
REQ-008 done  output  1  single-cycle pulse; Product is valid and final while done is high.
REQ-009 Product  output  8  registered unsigned result A*B; held until the next accepted start.

Function
REQ-010 The block SHALL implement shift-add multiplication using one instance of ripple_carry_adder (4-bit, Cin tied 0) as its only adder.
REQ-011 Internal state SHALL be: M[3:0] (multiplicand), Q[3:0] (multiplier/low product), ACC[3:0] (high partial product), C (adder carry), CNT[1:0] (iteration count).
REQ-012 FSM states SHALL be IDLE, CALC and DONE, with a 2-bit encoding and no other reachable states.
REQ-013 IDLE: if start=1 on a rising edge -> CALC; M<=A, Q<=B, ACC<=0, C<=0, CNT<=0; otherwise remain in IDLE with all registers unchanged.
REQ-014 CALC iteration (one per cycle): adder inputs ACC and M; if Q[0]=1 then {C,ACC} takes {Carry,Sum}, else {C,ACC} takes {0,ACC}; then {C,ACC,Q} is shifted right by one bit with 0 entering the MSB, all in the same edge.
REQ-015 CALC SHALL run exactly 4 iterations; CNT increments each iteration; on the iteration with CNT=3, state -> DONE and Product <= the post-shift {ACC,Q}.
REQ-016 DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-017 Latency: start accepted at edge N -> done high during the cycle following edge N+4 -> block back in IDLE after edge N+5; maximum throughput is one operation per 6 cycles when start is held high.
REQ-018 busy SHALL be 1 in CALC and DONE, 0 in IDLE; done SHALL be 1 only in DONE.
REQ-019 start asserted in CALC or DONE SHALL be ignored; A/B changes after acceptance SHALL NOT affect the result.
REQ-020 Product SHALL change only on the CALC->DONE transition or on reset; it SHALL never present an intermediate partial product.
REQ-021 Arithmetic is unsigned; the 8-bit result SHALL never overflow (max 15*15=225).
REQ-022 start held high continuously SHALL cause a new operation to be accepted on the first edge in IDLE, using the A/B present at that edge.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock edge, force state=IDLE, M=Q=ACC=0, C=0, CNT=0, Product=8'h00, busy=0, done=0.
REQ-024 Reset asserted during CALC or DONE SHALL abort the operation with no done pulse; Product SHALL read 0 afterwards.
REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-026 A=4'd13, B=4'd11, start pulsed one cycle -> busy high for 5 cycles, done single pulse 5 cycles after acceptance, Product=8'h8F (143).
REQ-027 A=4'd15, B=4'd15 -> Product=8'hE1 (225); A=4'd0, B=4'd9 -> Product=8'h00; A=4'd9, B=4'd0 -> Product=8'h00.
REQ-028 Accept A=3, B=5; 2 cycles later drive start=1 with A=7, B=7 for one cycle -> request ignored, Product=8'h0F, no second done pulse.
REQ-029 Accept A=12, B=10; assert rst_n=0 after 2 CALC cycles -> busy, done and Product go to 0 asynchronously; after release, A=2, B=3 -> Product=8'h06.
REQ-030 Exhaustive sweep of all 256 (A,B) pairs with start held high continuously -> every done pulse exactly 6 cycles apart, each Product equals A*B.
